// File: rtl/picorv32_mem_responder.sv
// Slave end of the PicoRV32 native memory handshake: word RAM with byte lanes,
// programmable wait states, a tohost result register and sticky error flags.
module picorv32_mem_responder #(
    parameter int unsigned MEM_WORDS   = 8192,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] TOHOST_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        tohost_valid,
    output logic [31:0] tohost_data,
    output logic        err_oob,
    output logic        err_proto,
    output logic [31:0] fetch_count
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RD_ZERO,
        RD_RAM,
        RD_TOHOST
    } rdsel_t;

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic        ready_q;

    rdsel_t      rdsel_q;
    logic [31:0] ram_rdata_q;
    logic [31:0] tohost_rd_q;
    logic [31:0] tohost_data_q;
    logic        tohost_valid_q;
    logic        err_oob_q;
    logic        err_proto_q;
    logic [31:0] fetch_count_q;

    logic [31:0] mem_q [MEM_WORDS];

    // With zero wait states the commit edge is also the acceptance edge, so the
    // commit path must see the live bus rather than the latched copy.
    logic [29:0] c_widx_d;
    logic [31:0] c_wdata_d;
    logic [3:0]  c_wstrb_d;
    logic        c_instr_d;
    logic        go_resp_d;
    logic        hit_tohost_d;
    logic        hit_ram_d;
    logic        is_write_d;
    logic        ram_we_d;
    logic        ram_re_d;
    logic [AW-1:0] ram_idx_d;
    logic [31:0] tohost_merged_d;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[1:0];

    always_comb begin
        c_widx_d  = addr_q;
        c_wdata_d = wdata_q;
        c_wstrb_d = wstrb_q;
        c_instr_d = instr_q;
        if (state_q == ST_IDLE) begin
            c_widx_d  = mem_addr[31:2];
            c_wdata_d = mem_wdata;
            c_wstrb_d = mem_wstrb;
            c_instr_d = mem_instr;
        end
    end

    always_comb begin
        go_resp_d = 1'b0;
        case (state_q)
            ST_IDLE: go_resp_d = mem_valid && (WAIT_CYCLES == 0);
            ST_WAIT: go_resp_d = mem_valid && (wait_cnt_q == 4'd0);
            default: go_resp_d = 1'b0;
        endcase
    end

    // tohost wins over RAM even if it falls inside the RAM range.
    assign hit_tohost_d = (c_widx_d == TOHOST_ADDR[31:2]);
    assign hit_ram_d    = !hit_tohost_d && ({2'b00, c_widx_d} < MEM_WORDS);
    assign is_write_d   = |c_wstrb_d;
    assign ram_idx_d    = c_widx_d[AW-1:0];
    assign ram_we_d     = go_resp_d && hit_ram_d && is_write_d;
    assign ram_re_d     = go_resp_d && hit_ram_d && !is_write_d;

    for (genvar gi = 0; gi < 4; gi++) begin : g_tohost_lane
        assign tohost_merged_d[8*gi +: 8] = c_wstrb_d[gi] ? c_wdata_d[8*gi +: 8]
                                                          : tohost_data_q[8*gi +: 8];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            addr_q      <= 30'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            instr_q     <= 1'b0;
            ready_q     <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (mem_valid) begin
                        addr_q  <= mem_addr[31:2];
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        instr_q <= mem_instr;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= ST_RESP;
                            ready_q <= 1'b1;
                        end else begin
                            wait_cnt_q <= 4'(WAIT_CYCLES - 1);
                            state_q    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!mem_valid) begin
                        err_proto_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (wait_cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdsel_q        <= RD_ZERO;
            tohost_rd_q    <= 32'd0;
            tohost_data_q  <= 32'd0;
            tohost_valid_q <= 1'b0;
            err_oob_q      <= 1'b0;
            fetch_count_q  <= 32'd0;
        end else if (go_resp_d) begin
            if (hit_tohost_d) begin
                if (is_write_d) begin
                    tohost_data_q  <= tohost_merged_d;
                    tohost_valid_q <= 1'b1;
                end else begin
                    tohost_rd_q <= tohost_data_q;
                    rdsel_q     <= RD_TOHOST;
                end
            end else if (hit_ram_d) begin
                if (!is_write_d) begin
                    rdsel_q <= RD_RAM;
                end
            end else begin
                err_oob_q <= 1'b1;
                if (!is_write_d) begin
                    rdsel_q <= RD_ZERO;
                end
            end
            if (c_instr_d && !is_write_d && (fetch_count_q != 32'hFFFF_FFFF)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    // Storage is left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we_d) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wstrb_d[i]) begin
                    mem_q[ram_idx_d][8*i +: 8] <= c_wdata_d[8*i +: 8];
                end
            end
        end
        if (ram_re_d) begin
            ram_rdata_q <= mem_q[ram_idx_d];
        end
    end

    always_comb begin
        mem_rdata = 32'd0;
        case (rdsel_q)
            RD_RAM:    mem_rdata = ram_rdata_q;
            RD_TOHOST: mem_rdata = tohost_rd_q;
            default:   mem_rdata = 32'd0;
        endcase
    end

    assign mem_ready    = ready_q;
    assign tohost_valid = tohost_valid_q;
    assign tohost_data  = tohost_data_q;
    assign err_oob      = err_oob_q;
    assign err_proto    = err_proto_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench: one responder with no wait states and one with three,
// sharing the request bus through a select bit.
module tb_picorv32_mem_responder;

    logic        clk;
    logic        resetn;
    logic        sel;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        valid0, ready0, tv0, oob0, proto0;
    logic [31:0] rdata0, td0, fc0;
    logic        valid3, ready3, tv3, oob3, proto3;
    logic [31:0] rdata3, td3, fc3;

    int tests;
    int fails;

    assign valid0 = valid & ~sel;
    assign valid3 = valid & sel;

    picorv32_mem_responder #(.MEM_WORDS(8192), .WAIT_CYCLES(0), .TOHOST_ADDR(32'h1000_0000)) u0 (
        .clk(clk), .resetn(resetn), .mem_valid(valid0), .mem_instr(instr), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(ready0), .mem_rdata(rdata0),
        .tohost_valid(tv0), .tohost_data(td0), .err_oob(oob0), .err_proto(proto0),
        .fetch_count(fc0)
    );

    picorv32_mem_responder #(.MEM_WORDS(8192), .WAIT_CYCLES(3), .TOHOST_ADDR(32'h1000_0000)) u3 (
        .clk(clk), .resetn(resetn), .mem_valid(valid3), .mem_instr(instr), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(ready3), .mem_rdata(rdata3),
        .tohost_valid(tv3), .tohost_data(td3), .err_oob(oob3), .err_proto(proto3),
        .fetch_count(fc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer; lat counts rising edges from first sampled valid to ready seen.
    task automatic xfer(input bit s, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st, input bit ins,
                        output logic [31:0] rd, output int lat);
        logic rdy;
        @(negedge clk);
        sel = s; addr = a; wdata = d; wstrb = st; instr = ins; valid = 1'b1;
        lat = 0;
        rdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            rdy = s ? ready3 : ready0;
            if (rdy) break;
        end
        rd = s ? rdata3 : rdata0;
        valid = 1'b0;
        check("xfer_ready_seen", {31'd0, rdy}, 32'd1);
        @(posedge clk); #1;
        check("ready_one_cycle", {31'd0, (s ? ready3 : ready0)}, 32'd0);
        $display("[TB] xfer dut=%0d addr=%h wdata=%h wstrb=%b instr=%0d rdata=%h lat=%0d",
                 s ? 3 : 0, a, d, st, ins, rd, lat);
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        tests = 0; fails = 0;
        resetn = 1'b0; sel = 1'b0; valid = 1'b0; instr = 1'b0;
        addr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_ready", {31'd0, ready0}, 32'd0);
        check("rst_rdata", rdata0, 32'd0);
        check("rst_tohost_valid", {31'd0, tv0}, 32'd0);
        check("rst_tohost_data", td0, 32'd0);
        check("rst_err_oob", {31'd0, oob0}, 32'd0);
        check("rst_err_proto", {31'd0, proto0}, 32'd0);
        check("rst_fetch_count", fc0, 32'd0);

        // Zero wait states: preload then fetch word 5
        xfer(0, 32'h0000_0014, 32'hDEAD_BEEF, 4'hF, 0, rd, lat);
        check("w0_write_lat", lat, 32'd1);
        xfer(0, 32'h0000_0014, 32'd0, 4'h0, 1, rd, lat);
        check("w0_fetch_lat", lat, 32'd1);
        check("w0_fetch_data", rd, 32'hDEAD_BEEF);
        check("w0_fetch_count", fc0, 32'd1);

        // Byte-lane merge on word 3
        xfer(0, 32'h0000_000C, 32'h1122_3344, 4'hF, 0, rd, lat);
        xfer(0, 32'h0000_000C, 32'hAABB_CCDD, 4'b0101, 0, rd, lat);
        xfer(0, 32'h0000_000C, 32'd0, 4'h0, 0, rd, lat);
        check("lane_merge", rd, 32'h11BB_33DD);
        check("data_read_no_fetch", fc0, 32'd1);
        xfer(0, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 1, rd, lat);
        check("rdata_held_over_write", rdata0, 32'h11BB_33DD);
        check("instr_write_no_fetch", fc0, 32'd1);

        // Result register
        check("tohost_idle", {31'd0, tv0}, 32'd0);
        xfer(0, 32'h1000_0000, 32'h0000_0001, 4'hF, 0, rd, lat);
        check("tohost_valid", {31'd0, tv0}, 32'd1);
        check("tohost_data", td0, 32'd1);
        xfer(0, 32'h1000_0000, 32'd0, 4'h0, 0, rd, lat);
        check("tohost_read", rd, 32'd1);
        xfer(0, 32'h1000_0000, 32'hAB00_0000, 4'b1000, 0, rd, lat);
        check("tohost_byte_merge", td0, 32'hAB00_0001);
        xfer(0, 32'h1000_0003, 32'd0, 4'h0, 0, rd, lat);
        check("tohost_read_lowbits", rd, 32'hAB00_0001);
        check("tohost_no_oob", {31'd0, oob0}, 32'd0);

        // Out of range: first word past RAM must not alias word 0
        xfer(0, 32'h0000_8000, 32'd0, 4'h0, 0, rd, lat);
        check("oob_read_lat", lat, 32'd1);
        check("oob_read_zero", rd, 32'd0);
        check("oob_flag", {31'd0, oob0}, 32'd1);
        xfer(0, 32'h0000_8000, 32'h5555_5555, 4'hF, 0, rd, lat);
        xfer(0, 32'h0000_0000, 32'd0, 4'h0, 0, rd, lat);
        check("oob_write_dropped", rd, 32'h0BAD_F00D);
        check("w0_no_proto", {31'd0, proto0}, 32'd0);

        // Three wait states
        xfer(1, 32'h0000_001C, 32'h1234_5678, 4'hF, 0, rd, lat);
        check("w3_write_lat", lat, 32'd4);
        xfer(1, 32'h0000_001C, 32'd0, 4'h0, 1, rd, lat);
        check("w3_read_lat", lat, 32'd4);
        check("w3_read_data", rd, 32'h1234_5678);
        check("w3_fetch_count", fc3, 32'd1);

        // Abandon a write in WAIT
        @(negedge clk);
        sel = 1'b1; addr = 32'h0000_001C; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; instr = 1'b0;
        valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        valid = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (ready3) seen++;
            end
            check("proto_no_ready", seen, 32'd0);
        end
        check("proto_flag", {31'd0, proto3}, 32'd1);
        $display("[TB] abandoned write dut=3 err_proto=%0d", proto3);
        xfer(1, 32'h0000_001C, 32'd0, 4'h0, 0, rd, lat);
        check("proto_ram_unchanged", rd, 32'h1234_5678);

        // Reset while u3 sits in WAIT
        @(negedge clk);
        sel = 1'b1; addr = 32'h0000_001C; wstrb = 4'h0; instr = 1'b0; valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("midrst_ready3", {31'd0, ready3}, 32'd0);
        check("midrst_rdata3", rdata3, 32'd0);
        check("midrst_proto3", {31'd0, proto3}, 32'd0);
        check("midrst_fetch3", fc3, 32'd0);
        check("midrst_tohost_valid0", {31'd0, tv0}, 32'd0);
        check("midrst_tohost_data0", td0, 32'd0);
        check("midrst_oob0", {31'd0, oob0}, 32'd0);
        check("midrst_fetch0", fc0, 32'd0);
        $display("[TB] reset during WAIT ready3=%0d rdata3=%h", ready3, rdata3);
        valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        xfer(1, 32'h0000_001C, 32'd0, 4'h0, 0, rd, lat);
        check("postrst_w3_lat", lat, 32'd4);
        check("postrst_w3_data", rd, 32'h1234_5678);
        xfer(0, 32'h0000_000C, 32'd0, 4'h0, 0, rd, lat);
        check("postrst_w0_data", rd, 32'h11BB_33DD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
